// File: rtl/issue_ctrl.sv
// issue_ctrl
// Dual-issue control at the read end of the instruction buffer. Looks at the
// two head entries each cycle and returns how many to pop (0, 1 or 2). It
// tracks outstanding long-latency destinations in a scoreboard, serializes
// special ops (CSR/idle/barrier) by draining the pipe around them, and counts
// cycles in which a valid head could not issue.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   flush                  pipeline flush from commit
//   a_*/b_*                head / head+1 entry: valid, class, dest, sources,
//                          src2-is-immediate flag
//   ex_ready               downstream accepts a pair this cycle
//   pipe_empty             nothing in flight past issue
//   wb_a_*/wb_b_*          long-latency writeback valid + destination
//   o_size                 entries popped and issued this cycle
//   serial_busy            serialization sequence in progress
//   sb_busy                scoreboard vector (bit 0 always 0)
//   stall_cnt              count of cycles a valid head did not issue
module issue_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        a_valid,
    input  logic        b_valid,
    input  logic [2:0]  a_class,
    input  logic [2:0]  b_class,
    input  logic [4:0]  a_dest,
    input  logic [4:0]  b_dest,
    input  logic [4:0]  a_r1,
    input  logic [4:0]  a_r2,
    input  logic [4:0]  b_r1,
    input  logic [4:0]  b_r2,
    input  logic        a_src2_is_imm,
    input  logic        b_src2_is_imm,
    input  logic        ex_ready,
    input  logic        pipe_empty,
    input  logic        wb_a_valid,
    input  logic        wb_b_valid,
    input  logic [4:0]  wb_a_dest,
    input  logic [4:0]  wb_b_dest,
    output logic [1:0]  o_size,
    output logic        serial_busy,
    output logic [31:0] sb_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SERIAL
    } state_t;

    localparam logic [2:0] CLS_BR   = 3'd1;
    localparam logic [2:0] CLS_MEM  = 3'd2;
    localparam logic [2:0] CLS_MUL  = 3'd3;
    localparam logic [2:0] CLS_DIV  = 3'd4;
    localparam logic [2:0] CLS_SPEC = 3'd5;

    state_t      state;
    state_t      state_next;
    logic [31:0] sb_set;
    logic [31:0] sb_clr;
    logic [31:0] sb_next;
    logic        a_busy;
    logic        b_busy;
    logic        a_long;
    logic        b_long;
    logic        a_muldiv;
    logic        b_muldiv;
    logic        b_hazard;
    logic        a_issue;
    logic        b_issue;

    // Bit 0 of the scoreboard is never set, so r0 sources never block.
    assign a_busy = sb_busy[a_r1] | (~a_src2_is_imm & sb_busy[a_r2]) | sb_busy[a_dest];
    assign b_busy = sb_busy[b_r1] | (~b_src2_is_imm & sb_busy[b_r2]) | sb_busy[b_dest];

    assign a_long   = (a_dest != 5'd0) && (a_class == CLS_MEM || a_class == CLS_MUL || a_class == CLS_DIV);
    assign b_long   = (b_dest != 5'd0) && (b_class == CLS_MEM || b_class == CLS_MUL || b_class == CLS_DIV);
    assign a_muldiv = (a_class == CLS_MUL) || (a_class == CLS_DIV);
    assign b_muldiv = (b_class == CLS_MUL) || (b_class == CLS_DIV);

    // B may not read or overwrite what A writes within the same pair.
    assign b_hazard = (a_dest != 5'd0) &&
                      ((b_r1 == a_dest) || (~b_src2_is_imm && (b_r2 == a_dest)) || (b_dest == a_dest));

    assign a_issue = resetn && !flush && ex_ready && (state == IDLE) && a_valid &&
                     !a_busy && (a_class != CLS_SPEC);

    // A branch closes the pair; memory and mul/div units are single-ported.
    assign b_issue = a_issue && b_valid && (b_class != CLS_SPEC) && (a_class != CLS_BR) &&
                     !((a_class == CLS_MEM) && (b_class == CLS_MEM)) &&
                     !(a_muldiv && b_muldiv) && !b_hazard && !b_busy;

    assign serial_busy = (state != IDLE);

    // Pop count and serialization sequencing. A special op is held at the
    // head until the pipe and scoreboard are empty, issued alone, and then
    // nothing else issues until it has left the pipe.
    always_comb begin
        state_next = state;
        o_size     = 2'd0;
        if (!resetn || flush) begin
            state_next = IDLE;
        end else if (ex_ready) begin
            case (state)
                IDLE: begin
                    if (a_issue) begin
                        o_size = b_issue ? 2'd2 : 2'd1;
                    end else if (a_valid && (a_class == CLS_SPEC)) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty && (sb_busy == 32'd0)) begin
                        o_size     = 2'd1;
                        state_next = SERIAL;
                    end
                end
                SERIAL: begin
                    if (pipe_empty) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Scoreboard set/clear vectors; a set on the same bit as a clear wins.
    always_comb begin
        sb_set = 32'd0;
        sb_clr = 32'd0;
        if (a_issue && a_long) begin
            sb_set[a_dest] = 1'b1;
        end
        if (b_issue && b_long) begin
            sb_set[b_dest] = 1'b1;
        end
        if (wb_a_valid) begin
            sb_clr[wb_a_dest] = 1'b1;
        end
        if (wb_b_valid) begin
            sb_clr[wb_b_dest] = 1'b1;
        end
        sb_next = ((sb_busy & ~sb_clr) | sb_set) & 32'hFFFF_FFFE;
    end

    // Flush behaves like reset for the FSM and scoreboard; the stall
    // counter survives flushes and only reset clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            sb_busy   <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            state <= state_next;
            if (flush) begin
                sb_busy <= 32'd0;
            end else begin
                sb_busy <= sb_next;
            end
            if (a_valid && (o_size == 2'd0) && !flush) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed vectors with hand-computed expectations,
// plus a behavioural model checked against the DUT on every falling edge.
module tb_issue_ctrl;

    localparam logic [2:0] ALU  = 3'd0;
    localparam logic [2:0] BR   = 3'd1;
    localparam logic [2:0] MEM  = 3'd2;
    localparam logic [2:0] MUL  = 3'd3;
    localparam logic [2:0] DIV  = 3'd4;
    localparam logic [2:0] SPEC = 3'd5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        a_valid, b_valid;
    logic [2:0]  a_class, b_class;
    logic [4:0]  a_dest, b_dest, a_r1, a_r2, b_r1, b_r2;
    logic        a_src2_is_imm, b_src2_is_imm;
    logic        ex_ready, pipe_empty;
    logic        wb_a_valid, wb_b_valid;
    logic [4:0]  wb_a_dest, wb_b_dest;
    logic [1:0]  o_size;
    logic        serial_busy;
    logic [31:0] sb_busy;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_class(a_class), .b_class(b_class),
        .a_dest(a_dest), .b_dest(b_dest),
        .a_r1(a_r1), .a_r2(a_r2), .b_r1(b_r1), .b_r2(b_r2),
        .a_src2_is_imm(a_src2_is_imm), .b_src2_is_imm(b_src2_is_imm),
        .ex_ready(ex_ready), .pipe_empty(pipe_empty),
        .wb_a_valid(wb_a_valid), .wb_b_valid(wb_b_valid),
        .wb_a_dest(wb_a_dest), .wb_b_dest(wb_b_dest),
        .o_size(o_size), .serial_busy(serial_busy),
        .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges, ending just after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setA(input logic v, input logic [2:0] cls, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic imm);
        a_valid = v; a_class = cls; a_dest = d; a_r1 = r1; a_r2 = r2; a_src2_is_imm = imm;
    endtask

    task automatic setB(input logic v, input logic [2:0] cls, input logic [4:0] d,
                        input logic [4:0] r1, input logic [4:0] r2, input logic imm);
        b_valid = v; b_class = cls; b_dest = d; b_r1 = r1; b_r2 = r2; b_src2_is_imm = imm;
    endtask

    task automatic setWb(input logic va, input logic [4:0] da, input logic vb, input logic [4:0] db);
        wb_a_valid = va; wb_a_dest = da; wb_b_valid = vb; wb_b_dest = db;
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy[32];
    bit          m_drain;
    bit          m_serial;
    int unsigned m_stall;

    function automatic bit blocked(input logic [4:0] r1, input logic [4:0] r2,
                                   input logic imm, input logic [4:0] d);
        return m_busy[r1] || (!imm && m_busy[r2]) || m_busy[d];
    endfunction

    function automatic bit anyBusy();
        for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit isLong(input logic [2:0] cls, input logic [4:0] d);
        return (d != 5'd0) && (cls == MEM || cls == MUL || cls == DIV);
    endfunction

    function automatic bit isMulDiv(input logic [2:0] cls);
        return (cls == MUL) || (cls == DIV);
    endfunction

    function automatic int pairSize();
        if (!a_valid || a_class == SPEC || blocked(a_r1, a_r2, a_src2_is_imm, a_dest)) return 0;
        if (!b_valid || b_class == SPEC || a_class == BR) return 1;
        if (a_class == MEM && b_class == MEM) return 1;
        if (isMulDiv(a_class) && isMulDiv(b_class)) return 1;
        if (a_dest != 5'd0 && (b_r1 == a_dest || (!b_src2_is_imm && b_r2 == a_dest) || b_dest == a_dest)) return 1;
        if (blocked(b_r1, b_r2, b_src2_is_imm, b_dest)) return 1;
        return 2;
    endfunction

    function automatic int expectedSize();
        if (!resetn || flush || !ex_ready) return 0;
        if (m_drain) return (pipe_empty && !anyBusy()) ? 1 : 0;
        if (m_serial) return 0;
        return pairSize();
    endfunction

    function automatic logic [31:0] modelVector();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Compare on every falling edge, then advance the model to the state the
    // DUT will hold after the next rising edge.
    initial begin : model_compare
        int sz;
        m_drain = 1'b0; m_serial = 1'b0; m_stall = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            sz = expectedSize();
            checkOutput("model o_size", {30'd0, o_size}, sz);
            checkOutput("model serial_busy", {31'd0, serial_busy}, {31'd0, m_drain || m_serial});
            checkOutput("model sb_busy", sb_busy, modelVector());
            checkOutput("model stall_cnt", stall_cnt, m_stall);
            if (!resetn) begin
                m_drain = 1'b0; m_serial = 1'b0; m_stall = 0;
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (a_valid && sz == 0 && !flush) m_stall++;
                if (flush) begin
                    m_drain = 1'b0; m_serial = 1'b0;
                    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                end else begin
                    if (wb_a_valid) m_busy[wb_a_dest] = 1'b0;
                    if (wb_b_valid) m_busy[wb_b_dest] = 1'b0;
                    if (sz >= 1 && !m_drain && isLong(a_class, a_dest)) m_busy[a_dest] = 1'b1;
                    if (sz == 2 && isLong(b_class, b_dest)) m_busy[b_dest] = 1'b1;
                    m_busy[0] = 1'b0;
                    if (ex_ready) begin
                        if (m_drain) begin
                            if (sz == 1) begin m_drain = 1'b0; m_serial = 1'b1; end
                        end else if (m_serial) begin
                            if (pipe_empty) m_serial = 1'b0;
                        end else if (a_valid && a_class == SPEC) begin
                            m_drain = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        resetn = 1'b0; flush = 1'b0; ex_ready = 1'b1; pipe_empty = 1'b1;
        setA(0, ALU, 0, 0, 0, 0);
        setB(0, ALU, 0, 0, 0, 0);
        setWb(0, 0, 0, 0);
        applyStimulus(1);
        settle();
        checkOutput("reset o_size", {30'd0, o_size}, 32'd0);
        checkOutput("reset serial_busy", {31'd0, serial_busy}, 32'd0);
        checkOutput("reset sb_busy", sb_busy, 32'd0);
        checkOutput("reset stall_cnt", stall_cnt, 32'd0);
        resetn = 1'b1;

        // valid head held with ex_ready low counts every cycle
        setA(1, ALU, 3, 1, 2, 0); ex_ready = 1'b0;
        applyStimulus(10);
        settle();
        checkOutput("ex_ready low o_size", {30'd0, o_size}, 32'd0);
        checkOutput("stall after 10", stall_cnt, 32'd10);

        // independent ALU pair
        ex_ready = 1'b1;
        setB(1, ALU, 5, 4, 6, 0);
        settle();
        checkOutput("alu pair", {30'd0, o_size}, 32'd2);
        applyStimulus(1);

        // load r7, dependent add waits for writeback
        setA(1, MEM, 7, 1, 0, 1); setB(0, ALU, 0, 0, 0, 0);
        settle();
        checkOutput("pair sb", sb_busy, 32'd0);
        checkOutput("load issue", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setA(1, ALU, 8, 7, 1, 0);
        settle();
        checkOutput("load sets r7", sb_busy, 32'h80);
        checkOutput("dep stalls", {30'd0, o_size}, 32'd0);
        applyStimulus(3);
        setWb(1, 7, 0, 0);
        settle();
        checkOutput("no wb bypass", {30'd0, o_size}, 32'd0);
        applyStimulus(1);
        setWb(0, 0, 0, 0);
        settle();
        checkOutput("wb clears r7", sb_busy, 32'd0);
        checkOutput("dep issues", {30'd0, o_size}, 32'd1);
        checkOutput("stall after dep", stall_cnt, 32'd14);
        applyStimulus(1);

        // pair-splitting rules
        setA(1, ALU, 9, 1, 2, 0); setB(1, ALU, 10, 9, 2, 0);
        settle();
        checkOutput("raw in pair", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setA(1, MEM, 11, 1, 0, 1); setB(1, MEM, 12, 2, 0, 1);
        settle();
        checkOutput("two mem", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setA(1, BR, 0, 3, 4, 0); setB(1, ALU, 13, 5, 6, 0); setWb(1, 11, 0, 0);
        settle();
        checkOutput("branch ends pair", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setWb(0, 0, 0, 0);
        setA(1, MUL, 14, 1, 2, 0); setB(1, DIV, 15, 3, 4, 0);
        settle();
        checkOutput("two muldiv", {30'd0, o_size}, 32'd1);
        applyStimulus(1);

        // set beats clear on the same bit; wb to r0 ignored
        setA(1, DIV, 16, 1, 2, 0); setB(0, ALU, 0, 0, 0, 0); setWb(1, 0, 1, 16);
        settle();
        checkOutput("div issue", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setWb(0, 0, 0, 0);
        setA(1, ALU, 18, 1, 2, 0); setB(1, MUL, 19, 2, 3, 0);
        settle();
        checkOutput("set wins", sb_busy, 32'h0001_4000);
        checkOutput("alu+mul pair", {30'd0, o_size}, 32'd2);
        applyStimulus(1);
        setA(0, ALU, 0, 0, 0, 0); setB(0, ALU, 0, 0, 0, 0); setWb(1, 14, 1, 16);
        applyStimulus(1);
        setWb(1, 19, 0, 0);
        applyStimulus(1);
        setWb(0, 0, 0, 0);
        settle();
        checkOutput("sb drained", sb_busy, 32'd0);

        // special op: drain, issue alone, serialize, resume
        setA(1, SPEC, 0, 0, 0, 1); pipe_empty = 1'b0;
        settle();
        checkOutput("spec idle o_size", {30'd0, o_size}, 32'd0);
        checkOutput("spec idle serial", {31'd0, serial_busy}, 32'd0);
        applyStimulus(1);
        settle();
        checkOutput("drain serial", {31'd0, serial_busy}, 32'd1);
        checkOutput("drain waits", {30'd0, o_size}, 32'd0);
        applyStimulus(2);
        pipe_empty = 1'b1;
        settle();
        checkOutput("drain pop", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setA(1, ALU, 3, 1, 2, 0); setB(1, ALU, 5, 4, 6, 0); pipe_empty = 1'b0;
        settle();
        checkOutput("serial busy", {31'd0, serial_busy}, 32'd1);
        checkOutput("serial holds", {30'd0, o_size}, 32'd0);
        applyStimulus(2);
        pipe_empty = 1'b1;
        settle();
        checkOutput("serial exit cycle", {30'd0, o_size}, 32'd0);
        applyStimulus(1);
        settle();
        checkOutput("back idle", {31'd0, serial_busy}, 32'd0);
        checkOutput("resume pair", {30'd0, o_size}, 32'd2);
        applyStimulus(1);

        // flush in DRAIN with r4 outstanding
        setA(1, DIV, 4, 1, 2, 0); setB(0, ALU, 0, 0, 0, 0);
        settle();
        checkOutput("div r4 issue", {30'd0, o_size}, 32'd1);
        applyStimulus(1);
        setA(1, SPEC, 0, 0, 0, 1);
        applyStimulus(1);
        settle();
        checkOutput("drain sb r4", sb_busy, 32'h10);
        checkOutput("drain sb wait", {30'd0, o_size}, 32'd0);
        flush = 1'b1;
        settle();
        checkOutput("flush o_size", {30'd0, o_size}, 32'd0);
        applyStimulus(1);
        flush = 1'b0; setA(0, ALU, 0, 0, 0, 0);
        settle();
        checkOutput("flush to idle", {31'd0, serial_busy}, 32'd0);
        checkOutput("flush clears sb", sb_busy, 32'd0);
        checkOutput("flush no stall", stall_cnt, 32'd21);

        // reset with work outstanding
        setA(1, MUL, 20, 1, 2, 0);
        applyStimulus(1);
        setA(1, ALU, 3, 1, 2, 0); setB(1, ALU, 5, 4, 6, 0); resetn = 1'b0;
        settle();
        checkOutput("reset forces o_size", {30'd0, o_size}, 32'd0);
        applyStimulus(1);
        settle();
        checkOutput("rst2 o_size", {30'd0, o_size}, 32'd0);
        checkOutput("rst2 serial", {31'd0, serial_busy}, 32'd0);
        checkOutput("rst2 sb", sb_busy, 32'd0);
        checkOutput("rst2 stall", stall_cnt, 32'd0);
        resetn = 1'b1;
        setA(0, ALU, 0, 0, 0, 0); setB(0, ALU, 0, 0, 0, 0);
        applyStimulus(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
